// File: rtl/mul_reg_seq_pkg.sv
// Shared types and default sizes for the multiplier-weight register-file sequencer.
package mul_reg_seq_pkg;

    localparam int I_WIDTH_DEF    = 8;
    localparam int F_WIDTH_DEF    = 8;
    localparam int N_DEF          = 3;
    localparam int PASS_WIDTH_DEF = 8;

    // Width of one signed fixed-point weight (integer + fractional bits).
    localparam int W_WIDTH = I_WIDTH_DEF + F_WIDTH_DEF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/mul_reg_seq_nz_next_find.sv
// Finds the lowest set bit of a nonzero-weight mask strictly above a given
// index. Only present when MUL_REG_SEQ_ZERO_SKIP_EN is defined.
`ifdef MUL_REG_SEQ_ZERO_SKIP_EN
module nz_next_find #(
    parameter int N  = 3,
    parameter int AW = 2
) (
    input  logic [N-1:0]  mask_i,
    input  logic [AW-1:0] cur_i,
    output logic [AW-1:0] idx_o,
    output logic          found_o
);

    // Scan from the top down so the last hit kept is the lowest qualifying index.
    always_comb begin
        idx_o   = {AW{1'b0}};
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_i[i] && (i > int'(cur_i))) begin
                idx_o   = AW'(i);
                found_o = 1'b1;
            end else begin
                idx_o   = idx_o;
                found_o = found_o;
            end
        end
    end

endmodule
`endif

// File: rtl/mul_reg_seq.sv
// Sequencer for one per-PE multiplier-weight register file: clear, load N
// weights from a valid/ready stream, then sweep the read address for a
// programmed number of passes. Optional MUL_REG_SEQ_ZERO_SKIP_EN makes the
// sweep skip addresses whose loaded weight was zero.
module mul_reg_seq
    import mul_reg_seq_pkg::*;
#(
    parameter int I_WIDTH     = I_WIDTH_DEF,
    parameter int F_WIDTH     = F_WIDTH_DEF,
    parameter int N           = N_DEF,
    parameter int ADDRS_WIDTH = $clog2(N),
    parameter int PASS_WIDTH  = PASS_WIDTH_DEF
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         start_i,
    input  logic [PASS_WIDTH-1:0]        num_pass_i,
    input  logic [I_WIDTH+F_WIDTH-1:0]   w_data_i,
    input  logic                         w_valid_i,
    output logic                         w_ready_o,
    input  logic                         stall_i,
    output logic                         mreg_rst_o,
    output logic                         mreg_wr_en_o,
    output logic [ADDRS_WIDTH-1:0]       mreg_wr_addrs_o,
    output logic [I_WIDTH+F_WIDTH-1:0]   mreg_wr_data_o,
    output logic [ADDRS_WIDTH-1:0]       mreg_rd_addrs_o,
    output logic                         rd_valid_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int WW = I_WIDTH + F_WIDTH;
    localparam logic [ADDRS_WIDTH-1:0] LAST_ADDR = ADDRS_WIDTH'(N - 1);

    state_e                  state_q, state_d;
    logic [ADDRS_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
    logic [ADDRS_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
    logic [PASS_WIDTH-1:0]   pass_cnt_q, pass_cnt_d;
    logic [PASS_WIDTH-1:0]   num_pass_q, num_pass_d;

    // Output flops, all loaded from the next state so they line up with state_q.
    logic                    mreg_rst_q;
    logic                    w_ready_q;
    logic                    rd_valid_q;
    logic                    busy_q;
    logic                    done_q;

    logic                    hs_s;
    logic [ADDRS_WIDTH-1:0]  first_rd_s;
    logic [ADDRS_WIDTH-1:0]  next_rd_s;
    logic                    last_in_pass_s;
    logic                    any_nz_s;

    assign hs_s = w_ready_q & w_valid_i;

`ifdef MUL_REG_SEQ_ZERO_SKIP_EN
    logic [N-1:0]            nz_q, nz_d;
    logic [ADDRS_WIDTH-1:0]  after_cur_idx_s;
    logic                    after_cur_found_s;
    logic [ADDRS_WIDTH-1:0]  after_zero_idx_s;
    logic                    after_zero_found_s;

    // Track which loaded weights are nonzero; the mask restarts on every job.
    always_comb begin
        nz_d = nz_q;
        if (state_q == ST_CLEAR) begin
            nz_d = {N{1'b0}};
        end else if ((state_q == ST_LOAD) && hs_s) begin
            nz_d[wr_cnt_q] = (w_data_i != {WW{1'b0}});
        end else begin
            nz_d = nz_q;
        end
    end

    // Next nonzero address after the one being presented.
    nz_next_find #(.N(N), .AW(ADDRS_WIDTH)) u_next_rd (
        .mask_i  (nz_q),
        .cur_i   (rd_cnt_q),
        .idx_o   (after_cur_idx_s),
        .found_o (after_cur_found_s)
    );

    // Lowest nonzero address above 0; uses nz_d so the final load beat counts.
    nz_next_find #(.N(N), .AW(ADDRS_WIDTH)) u_first_rd (
        .mask_i  (nz_d),
        .cur_i   ({ADDRS_WIDTH{1'b0}}),
        .idx_o   (after_zero_idx_s),
        .found_o (after_zero_found_s)
    );

    assign first_rd_s     = nz_d[0] ? {ADDRS_WIDTH{1'b0}} : after_zero_idx_s;
    assign any_nz_s       = nz_d[0] | after_zero_found_s;
    assign next_rd_s      = after_cur_idx_s;
    assign last_in_pass_s = ~after_cur_found_s;

    // Nonzero mask register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            nz_q <= {N{1'b0}};
        end else begin
            nz_q <= nz_d;
        end
    end
`else
    assign first_rd_s     = {ADDRS_WIDTH{1'b0}};
    assign any_nz_s       = 1'b1;
    assign next_rd_s      = rd_cnt_q + ADDRS_WIDTH'(1);
    assign last_in_pass_s = (rd_cnt_q == LAST_ADDR);
`endif

    // Next-state and counter update logic for the job sequence.
    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        pass_cnt_d = pass_cnt_q;
        num_pass_d = num_pass_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_CLEAR;
                    num_pass_d = num_pass_i;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                wr_cnt_d = {ADDRS_WIDTH{1'b0}};
                state_d  = ST_LOAD;
            end
            ST_LOAD: begin
                if (hs_s) begin
                    if (wr_cnt_q == LAST_ADDR) begin
                        wr_cnt_d   = {ADDRS_WIDTH{1'b0}};
                        rd_cnt_d   = first_rd_s;
                        pass_cnt_d = {PASS_WIDTH{1'b0}};
                        if ((num_pass_q == {PASS_WIDTH{1'b0}}) || !any_nz_s) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        wr_cnt_d = wr_cnt_q + ADDRS_WIDTH'(1);
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (stall_i) begin
                    state_d = ST_RUN;
                end else if (last_in_pass_s) begin
                    rd_cnt_d   = first_rd_s;
                    pass_cnt_d = pass_cnt_q + PASS_WIDTH'(1);
                    if (pass_cnt_q == (num_pass_q - PASS_WIDTH'(1))) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    rd_cnt_d = next_rd_s;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            wr_cnt_q   <= {ADDRS_WIDTH{1'b0}};
            rd_cnt_q   <= {ADDRS_WIDTH{1'b0}};
            pass_cnt_q <= {PASS_WIDTH{1'b0}};
            num_pass_q <= {PASS_WIDTH{1'b0}};
            mreg_rst_q <= 1'b0;
            w_ready_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            pass_cnt_q <= pass_cnt_d;
            num_pass_q <= num_pass_d;
            mreg_rst_q <= (state_d == ST_CLEAR);
            w_ready_q  <= (state_d == ST_LOAD);
            rd_valid_q <= (state_d == ST_RUN);
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_DONE);
        end
    end

    assign mreg_rst_o      = mreg_rst_q;
    assign w_ready_o       = w_ready_q;
    assign mreg_wr_en_o    = w_ready_q & w_valid_i;
    assign mreg_wr_addrs_o = wr_cnt_q;
    assign mreg_wr_data_o  = w_data_i;
    assign mreg_rd_addrs_o = rd_cnt_q;
    assign rd_valid_o      = rd_valid_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;

endmodule

// File: tb/tb_mul_reg_seq.sv
// Self-checking bench for mul_reg_seq: a cycle table for the nominal job,
// directed gap/stall/zero-pass/reset sequences, and randomized jobs checked
// against a transaction-level model of the write and read address streams.
module tb_mul_reg_seq;
    import mul_reg_seq_pkg::*;

    localparam int N  = 3;
    localparam int AW = $clog2(N);
    localparam int PW = 8;
    localparam int WW = W_WIDTH;

    logic          clk;
    logic          rst_n;
    logic          start_i;
    logic [PW-1:0] num_pass_i;
    logic [WW-1:0] w_data_i;
    logic          w_valid_i;
    logic          w_ready_o;
    logic          stall_i;
    logic          mreg_rst_o;
    logic          mreg_wr_en_o;
    logic [AW-1:0] mreg_wr_addrs_o;
    logic [WW-1:0] mreg_wr_data_o;
    logic [AW-1:0] mreg_rd_addrs_o;
    logic          rd_valid_o;
    logic          busy_o;
    logic          done_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WW-1:0] job_w [N];

    mul_reg_seq #(
        .I_WIDTH(8), .F_WIDTH(8), .N(N), .ADDRS_WIDTH(AW), .PASS_WIDTH(PW)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .start_i        (start_i),
        .num_pass_i     (num_pass_i),
        .w_data_i       (w_data_i),
        .w_valid_i      (w_valid_i),
        .w_ready_o      (w_ready_o),
        .stall_i        (stall_i),
        .mreg_rst_o     (mreg_rst_o),
        .mreg_wr_en_o   (mreg_wr_en_o),
        .mreg_wr_addrs_o(mreg_wr_addrs_o),
        .mreg_wr_data_o (mreg_wr_data_o),
        .mreg_rd_addrs_o(mreg_rd_addrs_o),
        .rd_valid_o     (rd_valid_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          rst;
        logic          wen;
        logic [AW-1:0] waddr;
        logic          rv;
        logic [AW-1:0] raddr;
        logic          done;
        logic          busy;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(logic r, logic we, int wa, logic rv, int ra, logic d, logic b);
        vec_t v;
        v.rst = r; v.wen = we; v.waddr = AW'(wa); v.rv = rv; v.raddr = AW'(ra);
        v.done = d; v.busy = b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag, input bit with_addr);
        chk({tag, "/mreg_rst"}, 32'(mreg_rst_o), 32'd0);
        chk({tag, "/wr_en"},    32'(mreg_wr_en_o), 32'd0);
        chk({tag, "/w_ready"},  32'(w_ready_o), 32'd0);
        chk({tag, "/rd_valid"}, 32'(rd_valid_o), 32'd0);
        chk({tag, "/busy"},     32'(busy_o), 32'd0);
        chk({tag, "/done"},     32'(done_o), 32'd0);
        if (with_addr) begin
            chk({tag, "/wr_addr"}, 32'(mreg_wr_addrs_o), 32'd0);
            chk({tag, "/rd_addr"}, 32'(mreg_rd_addrs_o), 32'd0);
        end
    endtask

    // One job from start to done. The model: writes are addresses 0..N-1 in
    // order carrying job_w; reads are the addresses of each pass concatenated,
    // each held while stall_i is high; done follows the last read (or the
    // last write if there is nothing to read).
    task automatic run_job(input int np, input bit directed, input int vpct,
                           input int spct, output int rd_cycles);
        int  rq [$];
        int  widx;
        int  c;
        int  gap;
        int  stl;
        bit  done_seen;
        bit  load_done;
        bit  exp_wen;
        bit  exp_rv;
        bit  exp_done;
        for (int p = 0; p < np; p++) begin
            for (int a = 0; a < N; a++) begin
`ifdef MUL_REG_SEQ_ZERO_SKIP_EN
                if (job_w[a] != '0) rq.push_back(a);
`else
                rq.push_back(a);
`endif
            end
        end
        cyc();
        start_i    = 1'b1;
        num_pass_i = PW'(np);
        w_valid_i  = 1'b0;
        stall_i    = 1'b0;
        #1;
        chk("job/idle_before_start", 32'(busy_o), 32'd0);
        widx = 0; c = 0; done_seen = 1'b0; rd_cycles = 0;
        gap  = directed ? 2 : 0;
        stl  = directed ? 3 : 0;
        while (!done_seen && c < 400) begin
            cyc();
            c++;
            start_i    = directed ? 1'b0 : 1'($urandom_range(1));
            num_pass_i = PW'($urandom);
            if (directed && widx == 1 && gap > 0) begin
                w_valid_i = 1'b0;
                gap--;
            end else begin
                w_valid_i = (widx < N) && (int'($urandom_range(99)) < vpct);
            end
            w_data_i = (widx < N) ? job_w[widx] : WW'($urandom);
            if (directed) begin
                stall_i = (widx == N) && (rq.size() > 0) && (rq[0] == 1) && (stl > 0);
                if (stall_i) stl--;
            end else begin
                stall_i = (int'($urandom_range(99)) < spct);
            end
            #1;
            load_done = (widx == N);
            exp_wen   = (c >= 2) && (widx < N) && w_valid_i;
            exp_rv    = load_done && (rq.size() > 0);
            exp_done  = load_done && (rq.size() == 0);
            chk("job/mreg_rst", 32'(mreg_rst_o), 32'(c == 1));
            chk("job/busy",     32'(busy_o), 32'd1);
            chk("job/w_ready",  32'(w_ready_o), 32'((c >= 2) && (widx < N)));
            chk("job/wr_en",    32'(mreg_wr_en_o), 32'(exp_wen));
            chk("job/rd_valid", 32'(rd_valid_o), 32'(exp_rv));
            chk("job/done",     32'(done_o), 32'(exp_done));
            if (exp_wen) begin
                chk("job/wr_addr", 32'(mreg_wr_addrs_o), 32'(widx));
                chk("job/wr_data", 32'(mreg_wr_data_o), 32'(job_w[widx]));
                widx++;
            end
            if (exp_rv) begin
                chk("job/rd_addr", 32'(mreg_rd_addrs_o), 32'(rq[0]));
                rd_cycles++;
                if (!stall_i) void'(rq.pop_front());
            end
            if (exp_done) done_seen = 1'b1;
        end
        chk("job/finished_in_budget", 32'(done_seen), 32'd1);
        cyc();
        start_i = 1'b0;
        stall_i = 1'b0;
        w_valid_i = 1'b0;
        #1;
        chk("job/idle_after_done", 32'(busy_o), 32'd0);
        chk("job/done_one_cycle", 32'(done_o), 32'd0);
    endtask

    initial begin
        int  rc;
        int  widx;
        bit  found;
        logic [WW-1:0] wt [N];

        rst_n = 1'b0; start_i = 1'b0; num_pass_i = '0; w_data_i = '0;
        w_valid_i = 1'b0; stall_i = 1'b0;
        #1;
        chk_quiet("reset", 1'b1);
        cyc(); cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk_quiet("idle", 1'b1);
        end

        // Nominal job, cycle-exact: entry i describes cycle i+1 after the start edge.
        tbl[0]  = mk(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        tbl[1]  = mk(1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1);
        tbl[2]  = mk(1'b0, 1'b1, 1, 1'b0, 0, 1'b0, 1'b1);
        tbl[3]  = mk(1'b0, 1'b1, 2, 1'b0, 0, 1'b0, 1'b1);
        tbl[4]  = mk(1'b0, 1'b0, 0, 1'b1, 0, 1'b0, 1'b1);
        tbl[5]  = mk(1'b0, 1'b0, 0, 1'b1, 1, 1'b0, 1'b1);
        tbl[6]  = mk(1'b0, 1'b0, 0, 1'b1, 2, 1'b0, 1'b1);
        tbl[7]  = mk(1'b0, 1'b0, 0, 1'b1, 0, 1'b0, 1'b1);
        tbl[8]  = mk(1'b0, 1'b0, 0, 1'b1, 1, 1'b0, 1'b1);
        tbl[9]  = mk(1'b0, 1'b0, 0, 1'b1, 2, 1'b0, 1'b1);
        tbl[10] = mk(1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b1);
        tbl[11] = mk(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        wt[0] = 16'h0100; wt[1] = 16'h0200; wt[2] = 16'h0300;
        widx = 0;
        start_i = 1'b1; num_pass_i = 8'd2; w_valid_i = 1'b1; w_data_i = wt[0];
        for (int c = 0; c < 12; c++) begin
            cyc();
            start_i   = 1'b0;
            w_valid_i = (widx < N);
            w_data_i  = (widx < N) ? wt[widx] : 16'h0000;
            #1;
            chk("tbl/mreg_rst", 32'(mreg_rst_o), 32'(tbl[c].rst));
            chk("tbl/wr_en",    32'(mreg_wr_en_o), 32'(tbl[c].wen));
            chk("tbl/rd_valid", 32'(rd_valid_o), 32'(tbl[c].rv));
            chk("tbl/done",     32'(done_o), 32'(tbl[c].done));
            chk("tbl/busy",     32'(busy_o), 32'(tbl[c].busy));
            if (tbl[c].wen) begin
                chk("tbl/wr_addr", 32'(mreg_wr_addrs_o), 32'(tbl[c].waddr));
                chk("tbl/wr_data", 32'(mreg_wr_data_o), 32'(wt[tbl[c].waddr]));
                widx++;
            end
            if (tbl[c].rv) chk("tbl/rd_addr", 32'(mreg_rd_addrs_o), 32'(tbl[c].raddr));
        end
        w_valid_i = 1'b0;

        // Valid gap between weights 1 and 2, stall of 3 cycles on read address 1.
        job_w[0] = 16'h0100; job_w[1] = 16'h0200; job_w[2] = 16'h0300;
        run_job(2, 1'b1, 100, 0, rc);
        chk("gapstall/read_cycles", 32'(rc), 32'd9);

        // Zero passes: load completes, then done with no reads.
        run_job(0, 1'b0, 100, 0, rc);
        chk("zero_pass/read_cycles", 32'(rc), 32'd0);

        // Reset in the middle of a read sweep.
        cyc();
        start_i = 1'b1; num_pass_i = 8'd2; w_valid_i = 1'b1; w_data_i = 16'h0100;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cyc();
            start_i = 1'b0;
            #1;
            found = rd_valid_o && (mreg_rd_addrs_o == AW'(1));
        end
        chk("midrst/reached_rd_addr1", 32'(found), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_quiet("midrst", 1'b1);
        w_valid_i = 1'b0;
        cyc();
        rst_n = 1'b1;
        job_w[0] = 16'h0111; job_w[1] = 16'h0222; job_w[2] = 16'h0333;
        run_job(1, 1'b0, 100, 0, rc);
        chk("midrst/fresh_job_reads", 32'(rc), 32'd3);

`ifdef MUL_REG_SEQ_ZERO_SKIP_EN
        job_w[0] = 16'h0100; job_w[1] = 16'h0000; job_w[2] = 16'h0300;
        run_job(2, 1'b0, 100, 0, rc);
        chk("zskip/read_cycles", 32'(rc), 32'd4);
        job_w[0] = 16'h0000; job_w[1] = 16'h0000; job_w[2] = 16'h0000;
        run_job(2, 1'b0, 100, 0, rc);
        chk("zskip_all_zero/read_cycles", 32'(rc), 32'd0);
`endif

        // Randomized jobs with random valid gaps, stalls and ignored starts.
        for (int j = 0; j < 12; j++) begin
            for (int a = 0; a < N; a++) begin
                job_w[a] = ($urandom_range(99) < 30) ? 16'h0000 : 16'($urandom);
            end
            run_job(int'($urandom_range(4)), 1'b0, int'($urandom_range(100, 50)),
                    int'($urandom_range(40)), rc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
